// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller holding read/write pointers in Gray code only.
// Define GRAY_FIFO_LEVEL_EN to add the registered occupancy output owv_level.
module gray_fifo_ctrl #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  iw_clk,
  input  logic                  iw_reset,
  input  logic                  iw_wr_req,
  input  logic                  iw_rd_req,
  output logic                  ow_wr_en,
  output logic [ADDR_WIDTH-1:0] owv_wr_addr,
  output logic                  ow_rd_en,
  output logic [ADDR_WIDTH-1:0] owv_rd_addr,
  output logic                  ow_full,
  output logic                  ow_empty,
  output logic [ADDR_WIDTH:0]   owv_wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   owv_rd_ptr_gray,
  output logic                  ow_overflow,
  output logic                  ow_underflow
`ifdef GRAY_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   owv_level
`endif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] ONE = PW'(1);
  // Full when the two MSBs of the Gray pointers differ and all lower bits match.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

  if (ADDR_WIDTH < 1) begin : g_bad_width
    $error("gray_fifo_ctrl: ADDR_WIDTH must be > 0");
  end

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0] wr_bin, rd_bin;
  logic [PW-1:0] wr_bin_next, rd_bin_next;
  logic [PW-1:0] wr_gray_next, rd_gray_next;
  logic          full_next, empty_next;

  assign ow_wr_en    = iw_wr_req & ~ow_full;
  assign ow_rd_en    = iw_rd_req & ~ow_empty;
  assign owv_wr_addr = wr_bin[ADDR_WIDTH-1:0];
  assign owv_rd_addr = rd_bin[ADDR_WIDTH-1:0];

  always_comb begin
    wr_bin       = gray2bin(owv_wr_ptr_gray);
    rd_bin       = gray2bin(owv_rd_ptr_gray);
    wr_bin_next  = ow_wr_en ? wr_bin + ONE : wr_bin;
    rd_bin_next  = ow_rd_en ? rd_bin + ONE : rd_bin;
    wr_gray_next = bin2gray(wr_bin_next);
    rd_gray_next = bin2gray(rd_bin_next);
    empty_next   = (wr_gray_next == rd_gray_next);
    full_next    = (wr_gray_next == (rd_gray_next ^ FULL_MASK));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iw_clk or posedge iw_reset) begin
    if (iw_reset) begin
      owv_wr_ptr_gray <= '0;
      owv_rd_ptr_gray <= '0;
      ow_full         <= 1'b0;
      ow_empty        <= 1'b1;
      ow_overflow     <= 1'b0;
      ow_underflow    <= 1'b0;
    end else begin
      owv_wr_ptr_gray <= wr_gray_next;
      owv_rd_ptr_gray <= rd_gray_next;
      ow_full         <= full_next;
      ow_empty        <= empty_next;
      ow_overflow     <= ow_overflow | (iw_wr_req & ow_full);
      ow_underflow    <= ow_underflow | (iw_rd_req & ow_empty);
    end
  end

`ifdef GRAY_FIFO_LEVEL_EN
  logic [PW-1:0] level_next;
  assign level_next = wr_bin_next - rd_bin_next;

  always_ff @(posedge iw_clk or posedge iw_reset) begin
    if (iw_reset) owv_level <= '0;
    else          owv_level <= level_next;
  end
`endif

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Self-checking bench for gray_fifo_ctrl (ADDR_WIDTH=2) against an occupancy-count model.
// Level checks are active when GRAY_FIFO_LEVEL_EN is defined for both bench and RTL.
module tb_gray_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          iw_clk = 1'b0;
  logic          iw_reset = 1'b1;
  logic          iw_wr_req = 1'b0;
  logic          iw_rd_req = 1'b0;
  logic          ow_wr_en, ow_rd_en, ow_full, ow_empty, ow_overflow, ow_underflow;
  logic [AW-1:0] owv_wr_addr, owv_rd_addr;
  logic [AW:0]   owv_wr_ptr_gray, owv_rd_ptr_gray;
`ifdef GRAY_FIFO_LEVEL_EN
  logic [AW:0]   owv_level;
`endif

  gray_fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .iw_clk          (iw_clk),
    .iw_reset        (iw_reset),
    .iw_wr_req       (iw_wr_req),
    .iw_rd_req       (iw_rd_req),
    .ow_wr_en        (ow_wr_en),
    .owv_wr_addr     (owv_wr_addr),
    .ow_rd_en        (ow_rd_en),
    .owv_rd_addr     (owv_rd_addr),
    .ow_full         (ow_full),
    .ow_empty        (ow_empty),
    .owv_wr_ptr_gray (owv_wr_ptr_gray),
    .owv_rd_ptr_gray (owv_rd_ptr_gray),
    .ow_overflow     (ow_overflow),
    .ow_underflow    (ow_underflow)
`ifdef GRAY_FIFO_LEVEL_EN
    ,
    .owv_level       (owv_level)
`endif
  );

  always #5 iw_clk = ~iw_clk;

  int checks = 0;
  int passed = 0;

  // Reference model: total accepted writes and reads since reset.
  int wr_cnt, rd_cnt;
  bit exp_ovf, exp_unf;
  bit exp_wr_en, exp_rd_en;

  function automatic logic [AW:0] gray_of(input int n);
    logic [AW:0] b;
    b = AW'(0) + (AW+1)'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  function automatic int occ();
    return wr_cnt - rd_cnt;
  endfunction

  task automatic model_clear();
    wr_cnt = 0; rd_cnt = 0; exp_ovf = 0; exp_unf = 0;
  endtask

  // Drive requests and compute the expected grants from the current occupancy.
  task automatic set_req(input bit wr, input bit rd);
    iw_wr_req = wr;
    iw_rd_req = rd;
    exp_wr_en = wr && (occ() < DEPTH);
    exp_rd_en = rd && (occ() > 0);
    #1;
  endtask

  task automatic tick();
    @(posedge iw_clk);
    if (iw_wr_req && occ() == DEPTH) exp_ovf = 1;
    if (iw_rd_req && occ() == 0)     exp_unf = 1;
    if (exp_wr_en) wr_cnt++;
    if (exp_rd_en) rd_cnt++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge iw_clk);
    iw_reset = 1; iw_wr_req = 0; iw_rd_req = 0;
    model_clear();
    @(negedge iw_clk);
    iw_reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (ow_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", ow_empty); else passed++;
    checks++; if (ow_full !== 1'b0) $display("FAIL reset_full: got %b want 0", ow_full); else passed++;
    checks++; if (owv_wr_ptr_gray !== 3'b000 || owv_rd_ptr_gray !== 3'b000)
      $display("FAIL reset_ptrs: got wr=%b rd=%b want 000/000", owv_wr_ptr_gray, owv_rd_ptr_gray); else passed++;
    checks++; if (ow_overflow !== 1'b0 || ow_underflow !== 1'b0)
      $display("FAIL reset_err: got ovf=%b unf=%b want 0/0", ow_overflow, ow_underflow); else passed++;
`ifdef GRAY_FIFO_LEVEL_EN
    checks++; if (owv_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", owv_level); else passed++;
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      set_req(1, 0);
      checks++; if (ow_wr_en !== 1'b1 || owv_wr_addr !== AW'(i))
        $display("FAIL fill_grant%0d: got en=%b addr=%0d want 1/%0d", i, ow_wr_en, owv_wr_addr, i); else passed++;
      tick();
    end
    checks++; if (ow_full !== 1'b1) $display("FAIL fill_full: got %b want 1", ow_full); else passed++;
    checks++; if (owv_wr_ptr_gray !== 3'b110 || owv_wr_addr !== 2'd0)
      $display("FAIL fill_ptr: got gray=%b addr=%0d want 110/0", owv_wr_ptr_gray, owv_wr_addr); else passed++;
`ifdef GRAY_FIFO_LEVEL_EN
    checks++; if (owv_level !== 3'd4) $display("FAIL fill_level: got %0d want 4", owv_level); else passed++;
`endif
    set_req(1, 0);
    checks++; if (ow_wr_en !== 1'b0) $display("FAIL overflow_grant: got %b want 0", ow_wr_en); else passed++;
    tick();
    checks++; if (ow_overflow !== 1'b1 || owv_wr_ptr_gray !== 3'b110)
      $display("FAIL overflow_state: got ovf=%b gray=%b want 1/110", ow_overflow, owv_wr_ptr_gray); else passed++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      set_req(0, 1);
      checks++; if (ow_rd_en !== 1'b1 || owv_rd_addr !== AW'(i))
        $display("FAIL drain_grant%0d: got en=%b addr=%0d want 1/%0d", i, ow_rd_en, owv_rd_addr, i); else passed++;
      tick();
    end
    checks++; if (ow_empty !== 1'b1 || owv_rd_ptr_gray !== 3'b110)
      $display("FAIL drain_state: got empty=%b gray=%b want 1/110", ow_empty, owv_rd_ptr_gray); else passed++;
    set_req(0, 1);
    checks++; if (ow_rd_en !== 1'b0) $display("FAIL underflow_grant: got %b want 0", ow_rd_en); else passed++;
    tick();
    checks++; if (ow_underflow !== 1'b1 || owv_rd_ptr_gray !== 3'b110)
      $display("FAIL underflow_state: got unf=%b gray=%b want 1/110", ow_underflow, owv_rd_ptr_gray); else passed++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) begin set_req(1, 0); tick(); end
    set_req(1, 1);
    checks++; if (ow_rd_en !== 1'b1 || ow_wr_en !== 1'b0)
      $display("FAIL both_full_grant: got rd=%b wr=%b want 1/0", ow_rd_en, ow_wr_en); else passed++;
    tick();
    checks++; if (ow_full !== 1'b0 || ow_empty !== 1'b0)
      $display("FAIL both_full_flags: got full=%b empty=%b want 0/0", ow_full, ow_empty); else passed++;
`ifdef GRAY_FIFO_LEVEL_EN
    checks++; if (owv_level !== 3'd3) $display("FAIL both_full_level: got %0d want 3", owv_level); else passed++;
`endif
    for (int i = 0; i < DEPTH - 1; i++) begin set_req(0, 1); tick(); end
    set_req(1, 1);
    checks++; if (ow_wr_en !== 1'b1 || ow_rd_en !== 1'b0)
      $display("FAIL both_empty_grant: got wr=%b rd=%b want 1/0", ow_wr_en, ow_rd_en); else passed++;
    tick();
    checks++; if (ow_empty !== 1'b0 || ow_full !== 1'b0)
      $display("FAIL both_empty_flags: got empty=%b full=%b want 0/0", ow_empty, ow_full); else passed++;
`ifdef GRAY_FIFO_LEVEL_EN
    checks++; if (owv_level !== 3'd1) $display("FAIL both_empty_level: got %0d want 1", owv_level); else passed++;
`endif
    set_req(0, 1); tick();
    set_req(0, 0);
  endtask

  task automatic test_wrap();
    logic [2:0] seq [9];
    logic [2:0] prev;
    seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    do_reset();
    #1;
    prev = owv_wr_ptr_gray;
    for (int i = 0; i <= 2 * DEPTH; i++) begin
      set_req(i < 2 * DEPTH, i > 0);
      tick();
      if (i < 2 * DEPTH) begin
        checks++; if (owv_wr_ptr_gray !== seq[i+1])
          $display("FAIL wrap_seq%0d: got %b want %b", i + 1, owv_wr_ptr_gray, seq[i+1]); else passed++;
        checks++; if ($countones(owv_wr_ptr_gray ^ prev) != 1)
          $display("FAIL wrap_onebit%0d: got %b->%b want one bit flip", i + 1, prev, owv_wr_ptr_gray); else passed++;
        prev = owv_wr_ptr_gray;
      end
    end
    set_req(0, 0);
    checks++; if (ow_empty !== 1'b1 || owv_rd_ptr_gray !== 3'b000)
      $display("FAIL wrap_end: got empty=%b rd=%b want 1/000", ow_empty, owv_rd_ptr_gray); else passed++;
  endtask

  task automatic test_random();
    bit wr, rd;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      wr = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 50);
      set_req(wr, rd);
      checks++; if (ow_wr_en !== exp_wr_en || ow_rd_en !== exp_rd_en)
        $display("FAIL rand_grant%0d: got wr=%b rd=%b want %b/%b", i, ow_wr_en, ow_rd_en, exp_wr_en, exp_rd_en); else passed++;
      checks++; if (owv_wr_addr !== AW'(wr_cnt % DEPTH) || owv_rd_addr !== AW'(rd_cnt % DEPTH))
        $display("FAIL rand_addr%0d: got wr=%0d rd=%0d want %0d/%0d", i, owv_wr_addr, owv_rd_addr,
                 wr_cnt % DEPTH, rd_cnt % DEPTH); else passed++;
      tick();
      checks++; if (ow_full !== (occ() == DEPTH) || ow_empty !== (occ() == 0))
        $display("FAIL rand_flags%0d: got full=%b empty=%b want occ=%0d", i, ow_full, ow_empty, occ()); else passed++;
      checks++; if (owv_wr_ptr_gray !== gray_of(wr_cnt) || owv_rd_ptr_gray !== gray_of(rd_cnt))
        $display("FAIL rand_ptr%0d: got wr=%b rd=%b want %b/%b", i, owv_wr_ptr_gray, owv_rd_ptr_gray,
                 gray_of(wr_cnt), gray_of(rd_cnt)); else passed++;
      checks++; if (ow_overflow !== exp_ovf || ow_underflow !== exp_unf)
        $display("FAIL rand_err%0d: got ovf=%b unf=%b want %b/%b", i, ow_overflow, ow_underflow, exp_ovf, exp_unf); else passed++;
`ifdef GRAY_FIFO_LEVEL_EN
      checks++; if (owv_level !== (AW+1)'(occ()))
        $display("FAIL rand_level%0d: got %0d want %0d", i, owv_level, occ()); else passed++;
`endif
    end
    set_req(0, 0);
  endtask

  task automatic test_reset_midcycle();
    do_reset();
    set_req(1, 0); tick();
    set_req(1, 1); tick();
    set_req(1, 0); tick();
    #2;
    iw_reset = 1;
    iw_wr_req = 0;
    model_clear();
    #1;
    checks++; if (ow_empty !== 1'b1 || ow_full !== 1'b0)
      $display("FAIL async_flags: got empty=%b full=%b want 1/0", ow_empty, ow_full); else passed++;
    checks++; if (owv_wr_ptr_gray !== 3'b000 || owv_rd_ptr_gray !== 3'b000 || owv_wr_addr !== 2'd0)
      $display("FAIL async_ptrs: got wr=%b rd=%b addr=%0d want 000/000/0", owv_wr_ptr_gray, owv_rd_ptr_gray,
               owv_wr_addr); else passed++;
    checks++; if (ow_overflow !== 1'b0 || ow_underflow !== 1'b0)
      $display("FAIL async_err: got ovf=%b unf=%b want 0/0", ow_overflow, ow_underflow); else passed++;
    @(negedge iw_clk);
    iw_reset = 0;
    set_req(1, 0);
    checks++; if (ow_wr_en !== 1'b1 || owv_wr_addr !== 2'd0)
      $display("FAIL post_reset_write: got en=%b addr=%0d want 1/0", ow_wr_en, owv_wr_addr); else passed++;
    tick();
    checks++; if (owv_wr_ptr_gray !== 3'b001 || ow_empty !== 1'b0)
      $display("FAIL post_reset_ptr: got gray=%b empty=%b want 001/0", owv_wr_ptr_gray, ow_empty); else passed++;
    set_req(0, 0);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_random();
    test_reset_midcycle();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gray_fifo_ctrl.md
# gray_fifo_ctrl

- Single-clock FIFO pointer controller built around Gray-coded incremental pointers.
- Accepts write and read requests and grants them against full/empty state.
- Produces binary RAM addresses for an external dual-port memory, plus the Gray-coded pointers themselves.
- Sits between requesters and a storage array. The Gray pointer outputs are the export path for a later clock-domain-crossing variant.

## Interface
- ADDR_WIDTH, 2, RAM address width; FIFO depth = 2^ADDR_WIDTH; must be > 0. Internal pointers are ADDR_WIDTH+1 bits.

- iw_clk  in  1  clock; all state updates on rising edge.
- iw_reset  in  1  reset; asynchronous, active-high.
- iw_wr_req  in  1  write request.
- iw_rd_req  in  1  read request.
- ow_wr_en  out  1  write granted this cycle; drives RAM write enable.
- owv_wr_addr  out  ADDR_WIDTH  binary write address; low bits of binary write pointer.
- ow_rd_en  out  1  read granted this cycle.
- owv_rd_addr  out  ADDR_WIDTH  binary read address; low bits of binary read pointer.
- ow_full  out  1  registered full flag.
- ow_empty  out  1  registered empty flag.
- owv_wr_ptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer.
- owv_rd_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer.
- ow_overflow  out  1  sticky: write requested while full.
- ow_underflow  out  1  sticky: read requested while empty.
- owv_level  out  ADDR_WIDTH+1  registered occupancy, 0..2^ADDR_WIDTH. Present only with GRAY_FIFO_LEVEL_EN.

## Operation
- **Pointer storage**
  - Both pointers are held in Gray form only.
  - Binary values are obtained by Gray-to-binary decode.
  - The next pointer is computed as binary + 1, then re-encoded to Gray.
- **Grants**
  - ow_wr_en = iw_wr_req & ~ow_full.
  - ow_rd_en = iw_rd_req & ~ow_empty.
  - A granted write advances the write pointer by 1 at the next edge. A granted read does the same for the read pointer.
- **Flags**, computed from the next-state pointers and registered:
  - Empty: wr_gray == rd_gray.
  - Full: wr_gray == {~rd_gray[ADDR_WIDTH:ADDR_WIDTH-1], rd_gray[ADDR_WIDTH-2:0]}.
  - When ADDR_WIDTH=1, full is the top two bits inverted, with no remaining bits.
- **Simultaneous requests**
  - Full state: the read is granted and the write is rejected; the result is not full with level 2^ADDR_WIDTH-1.
  - Empty state: the write is granted and the read is rejected; the result is not empty with level 1.
  - Otherwise: both are granted, pointers both advance, and flags and level are unchanged.
- **Wrap-around**
  - Pointers wrap from 2^(ADDR_WIDTH+1)-1 to 0.
  - Every pointer change flips exactly one Gray bit, including at the wrap.
- **Errors**
  - ow_overflow sets on iw_wr_req & ow_full.
  - ow_underflow sets on iw_rd_req & ow_empty.
  - Both stay set until reset. Rejected requests do not move pointers.
- **Reset**, asynchronous and immediate, without a clock edge:
  - Pointers = 0, ow_empty = 1, ow_full = 0.
  - Both error flags = 0, owv_level = 0.
  - Addresses = 0, so grants follow from the flags.
  - An in-flight request is discarded.

## Timing
- Grant outputs are combinational from requests and registered flags, with zero latency.
- Addresses are valid in the same cycle as the grant. Data is written/read at the same edge that advances the pointer.
- Pointers, flags, level and error flags update at the edge after the request: one-cycle latency.
- No combinational path from requests to flags or pointers.
- Throughput: one write and one read per cycle.

## Configuration
- GRAY_FIFO_LEVEL_EN
  - Defined: owv_level port and register exist.
    - Level = binary(wr_ptr) - binary(rd_ptr), modulo 2^(ADDR_WIDTH+1), registered from the next-state pointers.
  - Undefined: port and subtractor are absent; all other behaviour is identical.

## Test plan
All scenarios use ADDR_WIDTH=2.
1. Reset asserted then released.
   - Expect ow_empty=1, ow_full=0, both Gray pointers 3'b000, ow_overflow=0, ow_underflow=0, owv_level=0.
2. Four consecutive writes.
   - After the 4th edge: ow_full=1, wr Gray=3'b110, owv_wr_addr=0, level=4.
   - A 5th write gives ow_wr_en=0 and ow_overflow=1, with the pointer unchanged.
3. From full, four reads.
   - Expect ow_empty=1 and rd Gray=3'b110.
   - An extra read gives ow_rd_en=0 and ow_underflow=1.
4. Simultaneous write+read while full.
   - Expect ow_rd_en=1, ow_wr_en=0, then ow_full=0 and level=3.
   - Repeat while empty: ow_wr_en=1, ow_rd_en=0, then ow_empty=0 and level=1.
5. Eight write/read pairs, each write followed one cycle later by a read.
   - wr Gray sequence is 000,001,011,010,110,111,101,100,000.
   - Exactly one bit changes per step, and the FIFO is empty at the end.
6. Two entries queued, then reset pulsed between clock edges.
   - All outputs reach reset values before the next edge.
   - The first post-reset write lands at owv_wr_addr=0.
